uart_rx_ctrl: RTL

- Sequencing controller for the UART serial receive path.
- Detects the start bit and times mid-bit sampling from a baud counter. Assembles 8N1 frames LSB-first and validates the stop bit.
- Hands each byte to the consumer through a valid/ack holding register, flagging framing and overrun errors.
- Sits between the raw rx pin and the byte-level consumer, replacing free-running shift capture.

---
 rtl/uart_rx_ctrl_if.sv | 40 ++++
 rtl/uart_rx_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl_if
// Description : Byte-level port bundle of the UART receive controller: raw
//               serial input, consumer acknowledge, received byte and flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if;
   logic       rx;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   // Receiver side: takes the serial line, produces bytes and status
   modport master (
      input  rx,
      input  rx_ack,
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      output busy
   );

   // Line driver / byte consumer side
   modport slave (
      output rx,
      output rx_ack,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART 8N1 receive sequencer. Synchronises the rx pin, detects
//               the start bit, samples each bit mid-period from a baud
//               counter, checks the stop bit and hands the byte over through
//               a valid/ack holding register with framing/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
   parameter int FREQ = 12000000,
   parameter int BAUD = 9600,
   parameter int LIM  = FREQ / BAUD,
   parameter int HALF = LIM / 2
) (
   input  logic           clk,
   input  logic           nrst,
   uart_rx_ctrl_if.master bus
);

   localparam int                c_cnt_w   = 11;
   localparam logic [c_cnt_w-1:0] c_lim_m1  = c_cnt_w'(LIM - 1);
   localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_WAIT_HI = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   r_count;
   logic [c_cnt_w-1:0]   w_count_nxt;
   logic [3:0]           r_bit_cnt;
   logic [3:0]           w_bit_cnt_nxt;
   logic [7:0]           r_shift;
   logic [7:0]           w_shift_nxt;
   logic [1:0]           r_sync;
   logic                 w_rx_s;
   logic                 w_load;
   logic                 w_ferr;
   logic [7:0]           r_rx_data;
   logic                 r_rx_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 w_ack_ok;

   assign w_rx_s   = r_sync[1];
   assign w_ack_ok = bus.rx_ack & r_rx_valid;

   // Two-flop synchroniser for the asynchronous rx pin; idles high
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], bus.rx};
      end
   end

   // Sequencer state, baud counter, bit counter and shift register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   // Next-state logic: start qualification, mid-bit sampling, stop check
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_load        = 1'b0;
      w_ferr        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_count_nxt = '0;
            if (!w_rx_s) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_count == c_half_m1) begin
               w_count_nxt = '0;
               if (!w_rx_s) begin
                  w_state_nxt   = S_DATA;
                  w_bit_cnt_nxt = '0;
               end else begin
                  // Line went back high before mid-start: a glitch
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_count_nxt = r_count + 1'b1;
            end
         end
         S_DATA: begin
            if (r_count == c_lim_m1) begin
               w_count_nxt   = '0;
               w_shift_nxt   = {w_rx_s, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd7) begin
                  w_state_nxt = S_STOP;
               end
            end else begin
               w_count_nxt = r_count + 1'b1;
            end
         end
         S_STOP: begin
            if (r_count == c_lim_m1) begin
               w_count_nxt = '0;
               if (w_rx_s) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_WAIT_HI;
               end
            end else begin
               w_count_nxt = r_count + 1'b1;
            end
         end
         S_WAIT_HI: begin
            // Hold off until the line is released so a break flags only once
            if (w_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   // Holding register and status flags toward the consumer
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_ferr;
         if (w_load) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
            if (r_rx_valid && !bus.rx_ack) begin
               r_overrun <= 1'b1;
            end else if (w_ack_ok) begin
               r_overrun <= 1'b0;
            end
         end else if (w_ack_ok) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = r_rx_data;
   assign bus.rx_valid  = r_rx_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.overrun   = r_overrun;
   assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
